// File: rtl/text_vram_writer_pkg.sv
// -----------------------------------------------------------------------------
// text_vram_pkg
//  Shared definitions for the text VRAM writer: control-code constants, the
//  writer FSM state type, the default blank code and a byte classifier used
//  by the cursor decode.
// -----------------------------------------------------------------------------
package text_vram_pkg;

  localparam logic [7:0] C_CODE_BS   = 8'h08;  // backspace
  localparam logic [7:0] C_CODE_LF   = 8'h0A;  // line feed
  localparam logic [7:0] C_CODE_FF   = 8'h0C;  // form feed = clear screen
  localparam logic [7:0] C_CODE_CR   = 8'h0D;  // carriage return
  localparam logic [7:0] C_CODE_DEL  = 8'h7F;  // consumed, no effect
  localparam logic [7:0] C_BLANK_DEF = 8'h20;  // code used by all clears

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR_LINE,
    ST_CLR_ALL
  } state_t;

  typedef enum logic [2:0] {
    CC_PRINT,
    CC_CR,
    CC_LF,
    CC_BS,
    CC_FF,
    CC_NOP
  } code_class_t;

  // Printable: 0x20..0x7E and 0x80..0xFF. Every other code below 0x20 that is
  // not a known control, and 0x7F, is swallowed without effect.
  function automatic code_class_t classify(input logic [7:0] code);
    if (code == C_CODE_CR)                          return CC_CR;
    else if (code == C_CODE_LF)                     return CC_LF;
    else if (code == C_CODE_BS)                     return CC_BS;
    else if (code == C_CODE_FF)                     return CC_FF;
    else if (code >= 8'h20 && code != C_CODE_DEL)   return CC_PRINT;
    else                                            return CC_NOP;
  endfunction

endpackage

// File: rtl/text_vram_writer_if.sv
// -----------------------------------------------------------------------------
// text_vram_writer_if
//  Bundles the character byte stream (VLD/DAT/RDY) and the RAM write port
//  (WE/WAs/WDs) of the text VRAM writer.
//  master : the host side - drives the byte stream, observes ready and the
//           RAM write port.
//  slave  : the writer - consumes the byte stream, drives ready and the RAM
//           write port.
// -----------------------------------------------------------------------------
interface text_vram_writer_if #(
  parameter int C_DAT_W = 8,
  parameter int C_ADR_W = 10
);

  logic               VLD;  // input byte valid
  logic [C_DAT_W-1:0] DAT;  // input character / control code
  logic               RDY;  // byte accepted when VLD & RDY at a clock edge
  logic               WE;   // RAM write enable
  logic [C_ADR_W-1:0] WAs;  // RAM write address
  logic [C_DAT_W-1:0] WDs;  // RAM write data

  modport master (output VLD, DAT, input  RDY, WE, WAs, WDs);
  modport slave  (input  VLD, DAT, output RDY, WE, WAs, WDs);

endinterface

// File: rtl/text_vram_writer_fill_seq.sv
// -----------------------------------------------------------------------------
// vram_fill_seq
//  Emits a run of ascending RAM addresses, one per clock, starting at
//  i_start_adr for i_len cycles. A new start always restarts the run, even
//  while one is in progress. Out of reset it is already running a full-screen
//  run from address 0, so the screen is blanked right after reset release.
// Ports
//  clk, rst      clock, async active-high reset
//  i_start       load a new run (start address + length)
//  i_start_adr   first address of the run
//  i_len         run length in writes (>= 1)
//  o_we          a write address is presented this cycle
//  o_adr         address presented this cycle
//  o_done        the presented address is the last of the run
// -----------------------------------------------------------------------------
module vram_fill_seq #(
  parameter int C_ADR_W   = 10,
  parameter int C_RST_LEN = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [C_ADR_W-1:0] i_start_adr,
  input  logic [C_ADR_W:0]   i_len,
  output logic               o_we,
  output logic [C_ADR_W-1:0] o_adr,
  output logic               o_done
);

  logic               r_act;
  logic [C_ADR_W-1:0] r_adr;
  logic [C_ADR_W-1:0] r_last;
  logic [C_ADR_W-1:0] w_last;

  // Store the last address rather than a down-counter so done is one compare.
  assign w_last = i_start_adr + C_ADR_W'(i_len - 1'b1);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values; blocking here would chain updates in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act  <= 1'b1;
      r_adr  <= '0;
      r_last <= C_ADR_W'(C_RST_LEN - 1);
    end else if (i_start) begin
      r_act  <= 1'b1;
      r_adr  <= i_start_adr;
      r_last <= w_last;
    end else if (r_act) begin
      if (r_adr == r_last) r_act <= 1'b0;
      else                 r_adr <= r_adr + C_ADR_W'(1);
    end
  end

  assign o_we   = r_act;
  assign o_adr  = r_adr;
  assign o_done = r_act && (r_adr == r_last);

endmodule

// File: rtl/text_vram_writer.sv
// -----------------------------------------------------------------------------
// text_vram_writer
//  Terminal-style cursor engine feeding the write port of the character VRAM.
//  Printable bytes are written at the cursor and advance it with auto-wrap;
//  CR/LF/BS/FF move the cursor or clear. Every row advance blanks the new row,
//  a clear request blanks the whole screen. All RAM outputs are registered.
// Ports
//  CK_i       clock (RAM write clock)
//  AR_i       async reset, active-high
//  CLR_i      clear-screen request (same as FF)
//  bus        slave side of text_vram_writer_if: VLD/DAT/RDY byte stream,
//             WE/WAs/WDs RAM write port
//  CUR_COL_o  cursor column
//  CUR_ROW_o  cursor row
//  BUSY_o     high while a line or screen clear runs
// -----------------------------------------------------------------------------
module text_vram_writer
  import text_vram_pkg::*;
#(
  parameter int                 C_DAT_W = 8,
  parameter int                 C_ADR_W = 10,
  parameter int                 C_COLS  = 32,
  parameter int                 C_ROWS  = 32,
  parameter logic [C_DAT_W-1:0] C_BLANK = C_DAT_W'(C_BLANK_DEF)
) (
  input  logic                      CK_i,
  input  logic                      AR_i,
  input  logic                      CLR_i,
  text_vram_writer_if.slave         bus,
  output logic [$clog2(C_COLS)-1:0] CUR_COL_o,
  output logic [$clog2(C_ROWS)-1:0] CUR_ROW_o,
  output logic                      BUSY_o
);

  localparam int C_COL_W = $clog2(C_COLS);
  localparam int C_ROW_W = $clog2(C_ROWS);
  localparam int C_CELLS = C_COLS * C_ROWS;

  localparam logic [C_COL_W-1:0] C_COL_LAST   = C_COL_W'(C_COLS - 1);
  localparam logic [C_ROW_W-1:0] C_ROW_LAST   = C_ROW_W'(C_ROWS - 1);
  localparam logic [C_ADR_W:0]   C_LINE_LEN   = (C_ADR_W+1)'(C_COLS);
  localparam logic [C_ADR_W:0]   C_SCREEN_LEN = (C_ADR_W+1)'(C_CELLS);

  if (C_CELLS > 2**C_ADR_W) begin : g_bad_geometry
    $error("text_vram_writer: C_COLS*C_ROWS does not fit in C_ADR_W address bits");
  end

  state_t             r_state,    w_state_nxt;
  logic [C_COL_W-1:0] r_col,      w_col_nxt;
  logic [C_ROW_W-1:0] r_row,      w_row_nxt;
  logic [C_ADR_W-1:0] r_cur_adr,  w_cur_adr_nxt;   // row*C_COLS+col, tracked incrementally
  logic [C_ADR_W-1:0] r_row_base, w_row_base_nxt;  // row*C_COLS, tracked incrementally
  logic               r_we,       w_we_nxt;
  logic [C_ADR_W-1:0] r_wa,       w_wa_nxt;
  logic [C_DAT_W-1:0] r_wd,       w_wd_nxt;

  logic               w_fill_start;
  logic [C_ADR_W-1:0] w_fill_adr;
  logic [C_ADR_W:0]   w_fill_len;
  logic               w_fill_we;
  logic [C_ADR_W-1:0] w_fill_cur_adr;
  logic               w_fill_done;

  logic               w_row_adv;
  logic               w_clr_all;
  code_class_t        w_cls;

  vram_fill_seq #(
    .C_ADR_W  (C_ADR_W),
    .C_RST_LEN(C_CELLS)
  ) u_fill (
    .clk        (CK_i),
    .rst        (AR_i),
    .i_start    (w_fill_start),
    .i_start_adr(w_fill_adr),
    .i_len      (w_fill_len),
    .o_we       (w_fill_we),
    .o_adr      (w_fill_cur_adr),
    .o_done     (w_fill_done)
  );

  assign w_cls = classify(bus.DAT[7:0]);

  // NOTE: every signal written below gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_col_nxt      = r_col;
    w_row_nxt      = r_row;
    w_cur_adr_nxt  = r_cur_adr;
    w_row_base_nxt = r_row_base;
    w_we_nxt       = 1'b0;
    w_wa_nxt       = r_wa;
    w_wd_nxt       = r_wd;
    w_fill_start   = 1'b0;
    w_fill_adr     = '0;
    w_fill_len     = C_LINE_LEN;
    w_row_adv      = 1'b0;
    w_clr_all      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (CLR_i) begin
          w_clr_all = 1'b1;  // clear wins over a byte offered in the same cycle
        end else if (bus.VLD) begin
          case (w_cls)
            CC_PRINT: begin
              w_we_nxt = 1'b1;
              w_wa_nxt = r_cur_adr;
              w_wd_nxt = bus.DAT;
              if (r_col == C_COL_LAST) begin
                w_row_adv = 1'b1;
              end else begin
                w_col_nxt     = r_col + C_COL_W'(1);
                w_cur_adr_nxt = r_cur_adr + C_ADR_W'(1);
              end
            end
            CC_CR: begin
              w_col_nxt     = '0;
              w_cur_adr_nxt = r_row_base;
            end
            CC_LF: w_row_adv = 1'b1;
            CC_BS: begin
              if (r_col != '0) begin
                w_col_nxt     = r_col - C_COL_W'(1);
                w_cur_adr_nxt = r_cur_adr - C_ADR_W'(1);
              end
            end
            CC_FF:   w_clr_all = 1'b1;
            default: ;
          endcase
        end
      end
      ST_CLR_LINE, ST_CLR_ALL: begin
        if (CLR_i) begin
          w_clr_all = 1'b1;  // restart drops the write presented this cycle
        end else begin
          w_we_nxt = w_fill_we;
          w_wa_nxt = w_fill_cur_adr;
          w_wd_nxt = C_BLANK;
          if (w_fill_done) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_CLR_ALL;
    endcase

    // Row advance: cursor lands at column 0 of the next row (wrapping to the
    // top), then that row is blanked. A wrapped char's write is already in
    // w_we_nxt and lands one cycle before the first blank.
    if (w_row_adv) begin
      w_col_nxt = '0;
      if (r_row == C_ROW_LAST) begin
        w_row_nxt      = '0;
        w_row_base_nxt = '0;
      end else begin
        w_row_nxt      = r_row + C_ROW_W'(1);
        w_row_base_nxt = r_row_base + C_ADR_W'(C_COLS);
      end
      w_cur_adr_nxt = w_row_base_nxt;
      w_fill_start  = 1'b1;
      w_fill_adr    = w_row_base_nxt;
      w_fill_len    = C_LINE_LEN;
      w_state_nxt   = ST_CLR_LINE;
    end

    if (w_clr_all) begin
      w_col_nxt      = '0;
      w_row_nxt      = '0;
      w_cur_adr_nxt  = '0;
      w_row_base_nxt = '0;
      w_we_nxt       = 1'b0;
      w_fill_start   = 1'b1;
      w_fill_adr     = '0;
      w_fill_len     = C_SCREEN_LEN;
      w_state_nxt    = ST_CLR_ALL;
    end
  end

  always_ff @(posedge CK_i or posedge AR_i) begin
    if (AR_i) begin
      r_state    <= ST_CLR_ALL;
      r_col      <= '0;
      r_row      <= '0;
      r_cur_adr  <= '0;
      r_row_base <= '0;
      r_we       <= 1'b0;
      r_wa       <= '0;
      r_wd       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      r_cur_adr  <= w_cur_adr_nxt;
      r_row_base <= w_row_base_nxt;
      r_we       <= w_we_nxt;
      r_wa       <= w_wa_nxt;
      r_wd       <= w_wd_nxt;
    end
  end

  assign bus.RDY   = (r_state == ST_IDLE) && !CLR_i;
  assign bus.WE    = r_we;
  assign bus.WAs   = r_wa;
  assign bus.WDs   = r_wd;
  assign CUR_COL_o = r_col;
  assign CUR_ROW_o = r_row;
  assign BUSY_o    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_text_vram_writer.sv
// -----------------------------------------------------------------------------
// tb_text_vram_writer
//  Directed bench for text_vram_writer (32x32 screen, 10-bit RAM address).
//  Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_text_vram_writer;

  localparam int C_DAT_W = 8;
  localparam int C_ADR_W = 10;
  localparam int C_COLS  = 32;
  localparam int C_ROWS  = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [4:0] cur_col;
  logic [4:0] cur_row;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  text_vram_writer_if #(.C_DAT_W(C_DAT_W), .C_ADR_W(C_ADR_W)) vif ();

  text_vram_writer #(
    .C_DAT_W(C_DAT_W),
    .C_ADR_W(C_ADR_W),
    .C_COLS (C_COLS),
    .C_ROWS (C_ROWS),
    .C_BLANK(8'h20)
  ) dut (
    .CK_i     (clk),
    .AR_i     (rst),
    .CLR_i    (clr),
    .bus      (vif),
    .CUR_COL_o(cur_col),
    .CUR_ROW_o(cur_row),
    .BUSY_o   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Called on the falling edge where the first blank write is visible; ends
  // on the falling edge of the last one.
  task automatic expect_fill(input string tag, input int start, input int len);
    int n_bad     = 0;
    int first_bad = -1;
    check({tag, "_first_adr"}, 32'(vif.WAs), 32'(start));
    for (int i = 0; i < len; i++) begin
      if (i != 0) @(negedge clk);
      if (!(vif.WE === 1'b1 && vif.WAs === C_ADR_W'(start + i) && vif.WDs === 8'h20)) begin
        n_bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    check({tag, "_bad_writes"}, 32'(n_bad), 0);
    if (n_bad != 0) $display("  %s: first bad write at offset %0d", tag, first_bad);
  endtask

  task automatic wait_rdy(input string tag, input int budget);
    int n = 0;
    while (vif.RDY !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, 32'(vif.RDY), 1);
  endtask

  // Offer one byte for one cycle; returns on the falling edge where the
  // resulting write (if any) is visible.
  task automatic send(input logic [7:0] code);
    vif.VLD = 1'b1;
    vif.DAT = code;
    @(negedge clk);
    vif.VLD = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vif.VLD = 1'b0;
    vif.DAT = '0;

    // ---- reset state -------------------------------------------------------
    repeat (2) @(negedge clk);
    check("rst_we",   32'(vif.WE),  0);
    check("rst_wa",   32'(vif.WAs), 0);
    check("rst_wd",   32'(vif.WDs), 0);
    check("rst_busy", 32'(busy),    1);
    check("rst_rdy",  32'(vif.RDY), 0);
    check("rst_col",  32'(cur_col), 0);
    check("rst_row",  32'(cur_row), 0);

    // ---- power-up screen clear ---------------------------------------------
    rst = 1'b0;
    @(negedge clk);
    expect_fill("boot_clr", 0, 1024);
    check("boot_rdy",  32'(vif.RDY), 1);
    check("boot_busy", 32'(busy),    0);
    check("boot_col",  32'(cur_col), 0);
    check("boot_row",  32'(cur_row), 0);
    @(negedge clk);
    check("idle_we_low", 32'(vif.WE), 0);

    // ---- 'A','B' back to back ----------------------------------------------
    vif.VLD = 1'b1;
    vif.DAT = 8'h41;
    check("ab_rdy", 32'(vif.RDY), 1);
    @(negedge clk);
    check("a_we", 32'(vif.WE),  1);
    check("a_wa", 32'(vif.WAs), 0);
    check("a_wd", 32'(vif.WDs), 32'h41);
    vif.DAT = 8'h42;
    @(negedge clk);
    vif.VLD = 1'b0;
    check("b_we",   32'(vif.WE),  1);
    check("b_wa",   32'(vif.WAs), 1);
    check("b_wd",   32'(vif.WDs), 32'h42);
    check("ab_col", 32'(cur_col), 2);
    check("ab_row", 32'(cur_row), 0);
    @(negedge clk);
    check("ab_we_drop", 32'(vif.WE), 0);

    // ---- CR, BS (incl. saturation), ignored codes, high printable ----------
    send(8'h0D);
    check("cr_no_write", 32'(vif.WE),  0);
    check("cr_col",      32'(cur_col), 0);
    send(8'h63);
    check("cr_then_wa", 32'(vif.WAs), 0);
    check("cr_then_wd", 32'(vif.WDs), 32'h63);
    check("cr_then_col", 32'(cur_col), 1);
    send(8'h08);
    check("bs_no_write", 32'(vif.WE),  0);
    check("bs_col",      32'(cur_col), 0);
    send(8'h08);
    check("bs_sat_we",  32'(vif.WE),  0);
    check("bs_sat_col", 32'(cur_col), 0);
    send(8'h7F);
    check("del_no_write", 32'(vif.WE),  0);
    check("del_col",      32'(cur_col), 0);
    send(8'h01);
    check("ctl01_no_write", 32'(vif.WE), 0);
    send(8'h80);
    check("hi_we",  32'(vif.WE),  1);
    check("hi_wa",  32'(vif.WAs), 0);
    check("hi_wd",  32'(vif.WDs), 32'h80);
    check("hi_col", 32'(cur_col), 1);

    // ---- LF from row 0 blanks row 1 ----------------------------------------
    send(8'h0A);
    check("lf_no_write", 32'(vif.WE),  0);
    check("lf_col",      32'(cur_col), 0);
    check("lf_row",      32'(cur_row), 1);
    check("lf_busy",     32'(busy),    1);
    check("lf_rdy_low",  32'(vif.RDY), 0);
    @(negedge clk);
    expect_fill("lf_row1", 32, 32);
    check("lf_done_rdy", 32'(vif.RDY), 1);

    // ---- 32 'x' from (0,3): wrap then blank row 4 --------------------------
    send(8'h0A);
    wait_rdy("to_row2", 64);
    send(8'h0A);
    wait_rdy("to_row3", 64);
    check("row3_row", 32'(cur_row), 3);
    bad = 0;
    vif.VLD = 1'b1;
    vif.DAT = 8'h78;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (!(vif.WE === 1'b1 && vif.WAs === C_ADR_W'(96 + i) && vif.WDs === 8'h78)) bad++;
    end
    vif.VLD = 1'b0;
    check("xrun_bad_writes", 32'(bad),     0);
    check("xrun_last_wa",    32'(vif.WAs), 127);
    check("xrun_col",        32'(cur_col), 0);
    check("xrun_row",        32'(cur_row), 4);
    check("xrun_rdy_low",    32'(vif.RDY), 0);
    @(negedge clk);
    expect_fill("xrun_line", 128, 32);
    check("xrun_done_rdy", 32'(vif.RDY), 1);

    // ---- walk to row 31, col 5, then LF wraps to row 0 ---------------------
    for (int k = 0; k < 27; k++) begin
      send(8'h0A);
      wait_rdy("walk", 64);
    end
    check("walk_row", 32'(cur_row), 31);
    for (int k = 0; k < 5; k++) send(8'h61 + 8'(k));
    check("r31_last_wa", 32'(vif.WAs), 996);
    check("r31_col",     32'(cur_col), 5);
    send(8'h0A);
    check("wrap_lf_we",  32'(vif.WE),  0);
    check("wrap_lf_col", 32'(cur_col), 0);
    check("wrap_lf_row", 32'(cur_row), 0);
    @(negedge clk);
    expect_fill("wrap_lf_row0", 0, 32);
    check("wrap_lf_rdy", 32'(vif.RDY), 1);

    // ---- CLR_i on the 10th line-clear write --------------------------------
    send(8'h0A);
    @(negedge clk);
    repeat (9) @(negedge clk);
    check("abort_10th_wa", 32'(vif.WAs), 41);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("abort_gap_we", 32'(vif.WE),  0);
    check("abort_busy",   32'(busy),    1);
    check("abort_row",    32'(cur_row), 0);
    @(negedge clk);
    expect_fill("abort_clr_all", 0, 1024);
    check("abort_done_rdy", 32'(vif.RDY), 1);

    // ---- VLD and CLR_i in the same idle cycle ------------------------------
    vif.VLD = 1'b1;
    vif.DAT = 8'h5A;
    clr     = 1'b1;
    #1;
    check("vldclr_rdy", 32'(vif.RDY), 0);
    @(negedge clk);
    vif.VLD = 1'b0;
    clr     = 1'b0;
    check("vldclr_no_write", 32'(vif.WE), 0);
    check("vldclr_busy",     32'(busy),   1);
    @(negedge clk);
    expect_fill("vldclr_fill", 0, 1024);

    // ---- FF code clears the screen -----------------------------------------
    send(8'h4B);
    check("ff_pre_col", 32'(cur_col), 1);
    send(8'h0C);
    check("ff_no_write", 32'(vif.WE),  0);
    check("ff_col",      32'(cur_col), 0);
    check("ff_busy",     32'(busy),    1);
    @(negedge clk);
    expect_fill("ff_fill", 0, 1024);
    check("ff_done_rdy", 32'(vif.RDY), 1);

    // ---- reset in the middle of a line clear -------------------------------
    send(8'h0A);
    @(negedge clk);
    check("mid_rst_pre_wa", 32'(vif.WAs), 32);
    rst = 1'b1;
    #1;
    check("mid_rst_we",   32'(vif.WE),  0);
    check("mid_rst_busy", 32'(busy),    1);
    check("mid_rst_row",  32'(cur_row), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_fill("mid_rst_fill", 0, 1024);
    check("mid_rst_done_rdy", 32'(vif.RDY), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
